// File: rtl/bp_local_predictor_pkg.sv
// bp_pkg: 2-bit saturating counter type, encodings and update function shared by the branch predictor
package bp_pkg;
    typedef logic [1:0] ctr2_t;
    localparam ctr2_t SNT = 2'b00;
    localparam ctr2_t WNT = 2'b01;
    localparam ctr2_t WT = 2'b10;
    localparam ctr2_t ST = 2'b11;
    localparam ctr2_t PHT_RST = WNT;
    function automatic ctr2_t ctr2_next(input ctr2_t c, input logic taken);
        return taken ? ((c == SNT) ? WNT : (c == WNT) ? WT : ST)
                     : ((c == ST) ? WT : (c == WT) ? WNT : SNT);
    endfunction
endpackage

// File: rtl/bp_local_predictor_table.sv
// bp_table: 2**DEPTH_LOG x WIDTH register array; ports clk/rst, NRD combinational reads (raddr/rdata), one sync write (we/waddr/wdata)
module bp_table #(
    parameter int DEPTH_LOG = 4,
    parameter int WIDTH = 2,
    parameter int NRD = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NRD-1:0][DEPTH_LOG-1:0]   raddr,
    output logic [NRD-1:0][WIDTH-1:0]       rdata,
    input  logic                            we,
    input  logic [DEPTH_LOG-1:0]            waddr,
    input  logic [WIDTH-1:0]                wdata
);
    logic [WIDTH-1:0] mem [2**DEPTH_LOG];
    for (genvar g = 0; g < NRD; g++) begin : g_rd
        assign rdata[g] = mem[raddr[g]];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**DEPTH_LOG; i++) mem[i] <= RESET_VAL;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
endmodule

// File: rtl/bp_local_predictor.sv
// bp_local_predictor: local-history predictor; pcF->pred_takenF, branchM/actual_takenM/pred_takenM/pcM->mispredictM/flushD/E/M, branch_cnt/mispred_cnt stats
module bp_local_predictor
    import bp_pkg::*;
#(
    parameter int BHT_IDX_W = 10,
    parameter int HIST_W = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pcF,
    input  logic             branchM,
    input  logic             actual_takenM,
    input  logic             pred_takenM,
    input  logic [31:0]      pcM,
    output logic             pred_takenF,
    output logic             mispredictM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    logic [BHT_IDX_W-1:0] bidx_f, bidx_m;
    logic [HIST_W-1:0] hist_f, hist_m, pidx_f, pidx_m;
    ctr2_t ctr_f, ctr_m;
    logic unused_pc;
    assign unused_pc = ^{pcF, pcM};
    assign bidx_f = pcF[BHT_IDX_W+1:2];
    assign bidx_m = pcM[BHT_IDX_W+1:2];
    assign pidx_f = hist_f ^ pcF[HIST_W+1:2];
    assign pidx_m = hist_m ^ pcM[HIST_W+1:2];
    bp_table #(
        .DEPTH_LOG(BHT_IDX_W),
        .WIDTH(HIST_W),
        .NRD(2),
        .RESET_VAL('0)
    ) u_bht (
        .clk(clk),
        .rst(rst),
        .raddr({bidx_m, bidx_f}),
        .rdata({hist_m, hist_f}),
        .we(branchM),
        .waddr(bidx_m),
        .wdata({hist_m[HIST_W-2:0], actual_takenM})
    );
    bp_table #(
        .DEPTH_LOG(HIST_W),
        .WIDTH(2),
        .NRD(2),
        .RESET_VAL(PHT_RST)
    ) u_pht (
        .clk(clk),
        .rst(rst),
        .raddr({pidx_m, pidx_f}),
        .rdata({ctr_m, ctr_f}),
        .we(branchM),
        .waddr(pidx_m),
        .wdata(ctr2_next(ctr_m, actual_takenM))
    );
    assign pred_takenF = ~rst & ctr_f[1];
    assign mispredictM = ~rst & branchM & (actual_takenM ^ pred_takenM);
    assign flushD = mispredictM;
    assign flushE = mispredictM;
    assign flushM = mispredictM;
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt <= '0;
            mispred_cnt <= '0;
        end else if (branchM) begin
            branch_cnt <= branch_cnt + CNT_W'(1);
            mispred_cnt <= mispred_cnt + CNT_W'(mispredictM);
        end
    end
endmodule

// File: tb/tb_bp_local_predictor.sv
// tb_bp_local_predictor: randomized + directed scoreboard bench for bp_local_predictor
module tb_bp_local_predictor;
    logic clk = 1'b1;
    logic rst;
    logic [31:0] pcF, pcM;
    logic branchM, actual_takenM, pred_takenM;
    logic pred_takenF, mispredictM, flushD, flushE, flushM;
    logic [31:0] branch_cnt, mispred_cnt;

    always #5 clk = ~clk;

    bp_local_predictor dut (
        .clk(clk), .rst(rst), .pcF(pcF), .branchM(branchM),
        .actual_takenM(actual_takenM), .pred_takenM(pred_takenM), .pcM(pcM),
        .pred_takenF(pred_takenF), .mispredictM(mispredictM),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    typedef struct {
        logic pred;
        logic mis;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
        bit cnt_known;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int failures = 0;

    int hist_mdl[1024];
    int pht_mdl[256];
    int unsigned bcnt_mdl, mcnt_mdl;
    bit known = 0;

    function automatic int bidx(input logic [31:0] pc);
        return int'(pc[11:2]);
    endfunction
    function automatic int pidx(input logic [31:0] pc);
        return (hist_mdl[bidx(pc)] ^ int'(pc[9:2])) & 255;
    endfunction
    function automatic bit mdl_pred(input logic [31:0] pc);
        return pht_mdl[pidx(pc)] >= 2;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 1024; i++) hist_mdl[i] = 0;
        for (int i = 0; i < 256; i++) pht_mdl[i] = 1;
        bcnt_mdl = 0;
        mcnt_mdl = 0;
        known = 1;
    endtask

    task automatic step(input bit r, input logic [31:0] pf, input bit br, input bit act,
                        input bit pm, input logic [31:0] pcm);
        exp_t e;
        int b, p;
        rst = r; pcF = pf; branchM = br; actual_takenM = act; pred_takenM = pm; pcM = pcm;
        e.pred = r ? 1'b0 : mdl_pred(pf);
        e.mis = !r && br && (act != pm);
        e.bcnt = bcnt_mdl;
        e.mcnt = mcnt_mdl;
        e.cnt_known = known;
        q.push_back(e);
        @(posedge clk);
        if (r) mdl_reset();
        else if (br) begin
            b = bidx(pcm);
            p = pidx(pcm);
            pht_mdl[p] = act ? ((pht_mdl[p] < 3) ? pht_mdl[p] + 1 : 3)
                             : ((pht_mdl[p] > 0) ? pht_mdl[p] - 1 : 0);
            hist_mdl[b] = ((hist_mdl[b] << 1) | int'(act)) & 255;
            bcnt_mdl++;
            if (act != pm) mcnt_mdl++;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("pred_takenF", pred_takenF, e.pred);
            check("mispredictM", mispredictM, e.mis);
            check("flushDEM", {flushD, flushE, flushM}, {3{e.mis}});
            if (e.cnt_known) begin
                check("branch_cnt", branch_cnt, e.bcnt);
                check("mispred_cnt", mispred_cnt, e.mcnt);
            end
        end
    end

    initial begin
        logic [31:0] pcs[6];
        logic [31:0] pf, pm;
        bit br, act, prd;
        for (int i = 0; i < 1024; i++) hist_mdl[i] = 0;
        for (int i = 0; i < 256; i++) pht_mdl[i] = 1;
        bcnt_mdl = 0;
        mcnt_mdl = 0;
        // reset and sweep
        step(1, 32'h0, 0, 0, 0, 32'h0);
        step(1, 32'h4, 0, 0, 0, 32'h0);
        step(0, 32'h0, 0, 0, 0, 32'h0);
        step(0, 32'h4, 0, 0, 0, 32'h0);
        step(0, 32'hFFC, 0, 0, 0, 32'h0);
        // training: three mispredicted taken branches
        for (int i = 0; i < 3; i++) step(0, 32'h0, 1, 1, 0, 32'h100);
        check("hist_0x40_after3", dut.u_bht.mem[64], 32'h07);
        for (int i = 0; i < 7; i++) step(0, 32'h0, 1, 1, 0, 32'h100);
        check("hist_0x40_ff", dut.u_bht.mem[64], 32'hFF);
        step(0, 32'h100, 0, 0, 0, 32'h0);
        // saturation at pht[0xBF]
        for (int i = 0; i < 5; i++) step(0, 32'h0, 1, 1, 1, 32'h100);
        check("pht_bf_sat", dut.u_pht.mem[8'hBF], 32'h3);
        step(0, 32'h0, 1, 0, 1, 32'h100);
        check("pht_bf_dec", dut.u_pht.mem[8'hBF], 32'h2);
        step(0, 32'h2FC, 0, 0, 0, 32'h0);
        // correct prediction
        step(0, 32'h0, 1, 1, 1, 32'h100);
        step(0, 32'h0, 0, 0, 0, 32'h0);
        // collision from reset state
        step(1, 32'h0, 0, 0, 0, 32'h0);
        step(0, 32'h200, 1, 1, 0, 32'h200);
        check("bht_80_upd", dut.u_bht.mem[128], 32'h01);
        check("pht_80_upd", dut.u_pht.mem[128], 32'h2);
        step(0, 32'h200, 0, 0, 0, 32'h0);
        // non-branch, then reset concurrent with an update
        step(0, 32'h200, 0, 1, 0, 32'h100);
        check("bht_40_nobr", dut.u_bht.mem[64], 32'h00);
        step(1, 32'h100, 1, 1, 0, 32'h200);
        check("pht_80_rst", dut.u_pht.mem[128], 32'h1);
        check("bht_80_rst", dut.u_bht.mem[128], 32'h00);
        step(0, 32'h200, 0, 0, 0, 32'h0);
        // random traffic with aliasing PCs
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h200;
        pcs[3] = 32'h2FC; pcs[4] = 32'h1101; pcs[5] = 32'hABC0_0200;
        for (int n = 0; n < 400; n++) begin
            pf = ($urandom_range(0, 3) == 0) ? $urandom : pcs[$urandom_range(0, 5)];
            pm = ($urandom_range(0, 3) == 0) ? $urandom : pcs[$urandom_range(0, 5)];
            br = $urandom_range(0, 3) != 0;
            act = $urandom_range(0, 2) != 0;
            prd = $urandom_range(0, 1) ? mdl_pred(pm) : 1'($urandom_range(0, 1));
            step($urandom_range(0, 60) == 0, pf, br, act, prd, pm);
        end
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
